// File: rtl/turn_ram_scheduler_pkg.sv
// Shared game definitions: phase codes and size defaults.
// The same phase encoding is used by the player and HEX logic.
package turn_ram_scheduler_pkg;

  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 10;
  localparam int PHASE_W    = 3;

  typedef enum logic [PHASE_W-1:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_P1     = 3'd2,
    S_P2     = 3'd3,
    S_RESULT = 3'd4
  } state_e;

endpackage

// File: rtl/ram_access_pipe.sv
// Two-stage issue/return register pipe in front of the story RAM.
// Ports: clk_i/rst_ni (sync, active-low); wr_issue_i/wr_ack_en_i/
// rd_issue_i/addr_i/data_i issue one access; ram_* drive the RAM;
// wr_ack_o, rd_valid_o, rd_data_o, rd_launch_o, busy_o report status.
module ram_access_pipe #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_issue_i,
  input  logic              wr_ack_en_i,
  input  logic              rd_issue_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] ram_q_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wren_o,
  output logic              wr_ack_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_launch_o,
  output logic              busy_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wren_q;
  logic              ack_q;
  logic              rd1_q;
  logic              rd2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
      ack_q  <= 1'b0;
      rd1_q  <= 1'b0;
      rd2_q  <= 1'b0;
    end else begin
      wren_q <= wr_issue_i;
      ack_q  <= wr_issue_i & wr_ack_en_i;
      rd1_q  <= rd_issue_i;
      rd2_q  <= rd1_q;
      if (wr_issue_i | rd_issue_i)
        addr_q <= addr_i;
      if (wr_issue_i)
        data_q <= data_i;
    end
  end

  assign ram_addr_o  = addr_q;
  assign ram_data_o  = data_q;
  assign ram_wren_o  = wren_q;
  assign wr_ack_o    = ack_q;
  assign rd_valid_o  = rd2_q;
  // RAM q is valid the cycle after the address cycle; gate it so
  // rd_data is 0 outside the valid pulse.
  assign rd_data_o   = rd2_q ? ram_q_i : '0;
  assign rd_launch_o = rd1_q;
  assign busy_o      = wren_q | rd1_q | rd2_q;

endmodule

// File: rtl/turn_ram_scheduler.sv
// Game turn sequencer and sole owner of the ram32x10 story RAM port.
// Ports: clock/resetn (sync, active-low); start/p1_done/p2_done
// pulses; wr_req/wr_data/wr_ack write slot for player1; rd_req/
// rd_valid/rd_data read slot for player2; ram_* to the RAM; phase,
// p1_count, p2_addr, full, exhausted, busy status.
// Optional CLEAR_ON_START_EN: zero the RAM before each game.
module turn_ram_scheduler
  import turn_ram_scheduler_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               p1_done,
  input  logic               p2_done,
  input  logic               wr_req,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_ack,
  input  logic               rd_req,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic [ADDR_W-1:0]  ram_address,
  output logic [DATA_W-1:0]  ram_data,
  output logic               ram_wren,
  input  logic [DATA_W-1:0]  ram_q,
  output logic [PHASE_W-1:0] phase,
  output logic [ADDR_W:0]    p1_count,
  output logic [ADDR_W-1:0]  p2_addr,
  output logic               full,
  output logic               exhausted,
  output logic               busy
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE  = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W:0]   p1_count_q;
  logic [ADDR_W-1:0] p2_addr_q;
  logic              done_q;

  logic              wr_go;
  logic              rd_go;
  logic              clr_issue;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_data;
  logic              rd_launch;

  assign full      = (p1_count_q == FULL_CNT);
  assign exhausted = (state_q == S_P2) &&
                     ({1'b0, p2_addr_q} == p1_count_q);

  assign wr_go = (state_q == S_P1) & wr_req & ~busy & ~full;
  // Once p2_done is pending no new read may start.
  assign rd_go = (state_q == S_P2) & rd_req & ~busy &
                 ~exhausted & ~done_q;

`ifdef CLEAR_ON_START_EN
  logic [ADDR_W:0] clr_q;

  // Address 0 is issued on the start edge itself so the sweep's
  // DEPTH write cycles line up exactly with the S_CLEAR cycles.
  assign clr_issue = ((state_q == S_IDLE) & start) |
                     ((state_q == S_CLEAR) & (clr_q != FULL_CNT));
  assign clr_addr  = (state_q == S_IDLE) ? '0
                                         : clr_q[ADDR_W-1:0];
`else
  assign clr_issue = 1'b0;
  assign clr_addr  = '0;
`endif

  always_comb begin
    iss_addr = p1_count_q[ADDR_W-1:0];
    iss_data = wr_data;
    unique case (1'b1)
      clr_issue: begin
        iss_addr = clr_addr;
        iss_data = '0;
      end
      rd_go:   iss_addr = p2_addr_q;
      default: ;
    endcase
  end

  ram_access_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk_i       (clock),
    .rst_ni      (resetn),
    .wr_issue_i  (wr_go | clr_issue),
    .wr_ack_en_i (wr_go),
    .rd_issue_i  (rd_go),
    .addr_i      (iss_addr),
    .data_i      (iss_data),
    .ram_q_i     (ram_q),
    .ram_addr_o  (ram_address),
    .ram_data_o  (ram_data),
    .ram_wren_o  (ram_wren),
    .wr_ack_o    (wr_ack),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .rd_launch_o (rd_launch),
    .busy_o      (busy)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      p1_count_q <= '0;
      p2_addr_q  <= '0;
      done_q     <= 1'b0;
`ifdef CLEAR_ON_START_EN
      clr_q      <= '0;
`endif
    end else begin
      // p2_addr moves as the RAM address cycle ends, so the new
      // value shows alongside rd_valid.
      if (rd_launch)
        p2_addr_q <= p2_addr_q + ADR_ONE;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            p1_count_q <= '0;
            p2_addr_q  <= '0;
            done_q     <= 1'b0;
`ifdef CLEAR_ON_START_EN
            clr_q      <= CNT_ONE;
            state_q    <= S_CLEAR;
`else
            state_q    <= S_P1;
`endif
          end
        end
        S_CLEAR: begin
`ifdef CLEAR_ON_START_EN
          if (clr_q == FULL_CNT)
            state_q <= S_P1;
          else
            clr_q <= clr_q + CNT_ONE;
`else
          state_q <= S_P1;
`endif
        end
        S_P1: begin
          if (wr_go)
            p1_count_q <= p1_count_q + CNT_ONE;
          if (p1_done) begin
            if (!wr_go && (p1_count_q == '0))
              state_q <= S_RESULT;
            else
              state_q <= S_P2;
          end
        end
        S_P2: begin
          if (p2_done | done_q) begin
            if (rd_go | busy) begin
              done_q <= 1'b1;
            end else begin
              done_q  <= 1'b0;
              state_q <= S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (start)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign phase    = state_q;
  assign p1_count = p1_count_q;
  assign p2_addr  = p2_addr_q;

endmodule

// File: tb/tb_turn_ram_scheduler.sv
// Directed self-checking bench for turn_ram_scheduler.
// Includes a behavioural ram32x10 with 1-cycle read latency.
module tb_turn_ram_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start, p1_done, p2_done;
  logic       wr_req, rd_req;
  logic [9:0] wr_data;
  logic       wr_ack, rd_valid;
  logic [9:0] rd_data;
  logic [4:0] ram_address;
  logic [9:0] ram_data;
  logic       ram_wren;
  logic [9:0] ram_q;
  logic [2:0] phase;
  logic [5:0] p1_count;
  logic [4:0] p2_addr;
  logic       full, exhausted, busy;

  logic [9:0] mem [32];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 10'h3FF;
  end

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  turn_ram_scheduler dut (
    .clock       (clk),
    .resetn      (resetn),
    .start       (start),
    .p1_done     (p1_done),
    .p2_done     (p2_done),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .rd_req      (rd_req),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .phase       (phase),
    .p1_count    (p1_count),
    .p2_addr     (p2_addr),
    .full        (full),
    .exhausted   (exhausted),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit sweep);
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef CLEAR_ON_START_EN
    chk("clr_phase", 32'(phase), 32'd1);
    if (sweep) wr_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (sweep) begin
        chk("clr_wren", 32'(ram_wren), 32'd1);
        chk("clr_addr", 32'(ram_address), 32'(i));
        chk("clr_data", 32'(ram_data), 32'd0);
        chk("clr_ack", 32'(wr_ack), 32'd0);
      end
      tick();
    end
    wr_req = 1'b0;
    if (sweep) chk("clr_mem5", 32'(mem[5]), 32'd0);
`else
    if (sweep) chk("start_busy", 32'(busy), 32'd0);
`endif
    chk("start_phase", 32'(phase), 32'd2);
    chk("start_cnt", 32'(p1_count), 32'd0);
  endtask

  task automatic do_write(input logic [9:0] d, input int a);
    wr_data = d;
    wr_req  = 1'b1;
    tick();
    chk("wr_ack", 32'(wr_ack), 32'd1);
    chk("wr_wren", 32'(ram_wren), 32'd1);
    chk("wr_addr", 32'(ram_address), 32'(a));
    chk("wr_data", 32'(ram_data), 32'(d));
    chk("wr_cnt", 32'(p1_count), 32'(a + 1));
    wr_req = 1'b0;
    tick();
    chk("wr_ack_off", 32'(wr_ack), 32'd0);
  endtask

  task automatic do_read(input int a, input logic [9:0] d);
    rd_req = 1'b1;
    tick();
    chk("rd_addr", 32'(ram_address), 32'(a));
    chk("rd_wren", 32'(ram_wren), 32'd0);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_early", 32'(rd_valid), 32'd0);
    tick();
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_data", 32'(rd_data), 32'(d));
    chk("rd_ptr", 32'(p2_addr), 32'(a + 1));
    rd_req = 1'b0;
    tick();
    chk("rd_valid_off", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    p1_done = 1'b0;
    p2_done = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_data = '0;
    tick();
    tick();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_cnt", 32'(p1_count), 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    tick();

    // 1: reset while a read is in flight
    do_start(1'b0);
    do_write(10'h111, 0);
    p1_done = 1'b1;
    tick();
    p1_done = 1'b0;
    chk("t1_phase", 32'(phase), 32'd3);
    rd_req = 1'b1;
    tick();
    chk("t1_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    rd_req = 1'b0;
    tick();
    chk("t1_rdv", 32'(rd_valid), 32'd0);
    chk("t1_phase0", 32'(phase), 32'd0);
    chk("t1_cnt", 32'(p1_count), 32'd0);
    chk("t1_p2", 32'(p2_addr), 32'd0);
    chk("t1_busy0", 32'(busy), 32'd0);
    resetn = 1'b1;
    tick();
    chk("t1_rdv2", 32'(rd_valid), 32'd0);

    // 2: three writes then hand over to player2
    do_start(1'b0);
    do_write(10'h155, 0);
    do_write(10'h2AA, 1);
    do_write(10'h0F0, 2);
    chk("t2_cnt", 32'(p1_count), 32'd3);
    p1_done = 1'b1;
    tick();
    p1_done = 1'b0;
    chk("t2_phase", 32'(phase), 32'd3);

    // 3: three reads, fourth ignored
    do_read(0, 10'h155);
    do_read(1, 10'h2AA);
    do_read(2, 10'h0F0);
    chk("t3_exh", 32'(exhausted), 32'd1);
    rd_req = 1'b1;
    tick();
    tick();
    chk("t3_rdv4", 32'(rd_valid), 32'd0);
    tick();
    chk("t3_rdv4b", 32'(rd_valid), 32'd0);
    chk("t3_p2", 32'(p2_addr), 32'd3);
    rd_req  = 1'b0;
    p2_done = 1'b1;
    tick();
    p2_done = 1'b0;
    chk("t3_phase", 32'(phase), 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_idle", 32'(phase), 32'd0);

    // 4: fill to DEPTH, 33rd write ignored
    do_start(1'b1);
    for (int i = 0; i < 32; i++)
      do_write(10'(i) ^ 10'h2A5, i);
    chk("t4_full", 32'(full), 32'd1);
    wr_data = 10'h001;
    wr_req  = 1'b1;
    tick();
    chk("t4_ack33", 32'(wr_ack), 32'd0);
    chk("t4_wren33", 32'(ram_wren), 32'd0);
    tick();
    chk("t4_ack33b", 32'(wr_ack), 32'd0);
    chk("t4_wren33b", 32'(ram_wren), 32'd0);
    wr_req = 1'b0;
    chk("t4_cnt", 32'(p1_count), 32'd32);
    p1_done = 1'b1;
    tick();
    p1_done = 1'b0;
    chk("t4_phase", 32'(phase), 32'd3);
    do_read(0, 10'h2A5);
    do_read(1, 10'h2A4);
    chk("t4_exh", 32'(exhausted), 32'd0);
    p2_done = 1'b1;
    tick();
    p2_done = 1'b0;
    chk("t4_res", 32'(phase), 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;

    // 5a: empty game goes straight to RESULT
    do_start(1'b0);
    p1_done = 1'b1;
    tick();
    p1_done = 1'b0;
    chk("t5_res", 32'(phase), 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_idle", 32'(phase), 32'd0);

    // 5b: write on the same edge as p1_done
    do_start(1'b0);
    wr_data = 10'h3C3;
    wr_req  = 1'b1;
    p1_done = 1'b1;
    tick();
    wr_req  = 1'b0;
    p1_done = 1'b0;
    chk("t5_ack", 32'(wr_ack), 32'd1);
    chk("t5_addr", 32'(ram_address), 32'd0);
    chk("t5_cnt", 32'(p1_count), 32'd1);
    chk("t5_p2", 32'(phase), 32'd3);
    tick();

    // p2_done while a read is in flight
    rd_req = 1'b1;
    tick();
    p2_done = 1'b1;
    tick();
    p2_done = 1'b0;
    chk("t5_rdv", 32'(rd_valid), 32'd1);
    chk("t5_rdd", 32'(rd_data), 32'h3C3);
    chk("t5_hold", 32'(phase), 32'd3);
    rd_req = 1'b0;
    tick();
    tick();
    chk("t5_done", 32'(phase), 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_end", 32'(phase), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
